// File: rtl/eth_pkg.sv
// Shared Ethernet framing constants, header layout and TX state encoding.
// Used by the Ethernet header serializer and the ARP/IP transmit paths.
package eth_pkg;

  localparam int ETH_HDR_LEN       = 14;
  localparam int ETH_MIN_FRAME_LEN = 60;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HEADER  = 2'd1,
    ST_PAYLOAD = 2'd2,
    ST_PAD     = 2'd3
  } tx_state_e;

  typedef struct packed {
    logic [47:0] dest_mac;
    logic [47:0] src_mac;
    logic [15:0] eth_type;
  } eth_hdr_t;

  // Byte idx of the header in wire order: dest MAC, src MAC, EtherType, MSB first.
  function automatic logic [7:0] hdr_byte(eth_hdr_t h, logic [3:0] idx);
    logic [ETH_HDR_LEN*8-1:0] flat;
    flat = h;
    return flat[8*(ETH_HDR_LEN-1-int'(idx)) +: 8];
  endfunction

endpackage

// File: rtl/eth_hdr_axis_tx_if.sv
// Handshake bundles for the Ethernet TX path: a parallel header channel
// and an 8-bit AXI-stream channel.
interface eth_hdr_if;
  logic        valid;
  logic        ready;
  logic [47:0] dest_mac;
  logic [47:0] src_mac;
  logic [15:0] eth_type;

  modport master (output valid, dest_mac, src_mac, eth_type, input ready);
  modport slave  (input valid, dest_mac, src_mac, eth_type, output ready);
endinterface

interface axis8_if;
  logic [7:0] tdata;
  logic       tvalid;
  logic       tready;
  logic       tlast;
  logic       tuser;

  modport master (output tdata, tvalid, tlast, tuser, input tready);
  modport slave  (input tdata, tvalid, tlast, tuser, output tready);
endinterface

// File: rtl/axis_out_reg.sv
// Single-stage AXI-stream output register; load_ok tells the producer
// that a byte offered this cycle will be captured.
module axis_out_reg (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] data,
  input  logic       last,
  input  logic       user,
  output logic       load_ok,
  axis8_if.master    m
);

  assign load_ok = !m.tvalid || m.tready;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (rst) begin
      m.tvalid <= 1'b0;
      m.tdata  <= '0;
      m.tlast  <= 1'b0;
      m.tuser  <= 1'b0;
    end else if (load_ok) begin
      m.tvalid <= load;
      if (load) begin
        m.tdata <= data;
        m.tlast <= last;
        m.tuser <= user;
      end
    end
  end

endmodule

// File: rtl/eth_hdr_axis_tx.sv
// Ethernet frame serializer: 14-byte header from a parallel bus, then the
// payload stream, zero-padded up to MIN_FRAME_LENGTH when enabled.
module eth_hdr_axis_tx
  import eth_pkg::*;
#(
  parameter bit ENABLE_PADDING   = 1'b1,
  parameter int MIN_FRAME_LENGTH = ETH_MIN_FRAME_LEN
) (
  input  logic     clk,
  input  logic     rst,
  eth_hdr_if.slave s_eth_hdr,
  axis8_if.slave   s_eth_payload_axis,
  axis8_if.master  m_axis,
  output logic     busy
);

  localparam logic [16:0] MIN_LEN = 17'(MIN_FRAME_LENGTH);

  tx_state_e   state;
  eth_hdr_t    hdr;
  logic [15:0] byte_cnt;
  logic [3:0]  ptr;
  logic        pad_user;

  logic        load_ok;
  logic        out_load;
  logic [7:0]  out_data;
  logic        out_last;
  logic        out_user;
  logic [16:0] cnt_inc;
  logic [15:0] cnt_next;
  logic        pad_needed;
  logic        pad_last;

  assign s_eth_hdr.ready          = (state == ST_IDLE) && !rst;
  assign s_eth_payload_axis.tready = (state == ST_PAYLOAD) && load_ok;
  assign busy                     = (state != ST_IDLE);

  // NOTE: every always_comb output gets a default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    cnt_inc    = {1'b0, byte_cnt} + 17'd1;
    cnt_next   = (byte_cnt == 16'hFFFF) ? byte_cnt : cnt_inc[15:0];
    pad_needed = ENABLE_PADDING && (cnt_inc < MIN_LEN);
    pad_last   = (cnt_inc == MIN_LEN);
    out_load   = 1'b0;
    out_data   = 8'h00;
    out_last   = 1'b0;
    out_user   = 1'b0;
    case (state)
      ST_HEADER: begin
        out_load = 1'b1;
        out_data = hdr_byte(hdr, ptr);
      end
      ST_PAYLOAD: begin
        out_load = s_eth_payload_axis.tvalid;
        out_data = s_eth_payload_axis.tdata;
        out_last = s_eth_payload_axis.tlast && !pad_needed;
        out_user = out_last && s_eth_payload_axis.tuser;
      end
      ST_PAD: begin
        out_load = 1'b1;
        out_last = pad_last;
        out_user = pad_last && pad_user;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      hdr      <= '0;
      byte_cnt <= '0;
      ptr      <= '0;
      pad_user <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (s_eth_hdr.valid) begin
            hdr      <= '{s_eth_hdr.dest_mac, s_eth_hdr.src_mac, s_eth_hdr.eth_type};
            byte_cnt <= '0;
            ptr      <= '0;
            state    <= ST_HEADER;
          end
        end
        ST_HEADER: begin
          if (load_ok) begin
            ptr      <= ptr + 4'd1;
            byte_cnt <= cnt_next;
            if (ptr == 4'(ETH_HDR_LEN - 1)) state <= ST_PAYLOAD;
          end
        end
        ST_PAYLOAD: begin
          if (load_ok && s_eth_payload_axis.tvalid) begin
            byte_cnt <= cnt_next;
            if (s_eth_payload_axis.tlast) begin
              // A short frame keeps its error flag until the final pad byte.
              if (pad_needed) begin
                pad_user <= s_eth_payload_axis.tuser;
                state    <= ST_PAD;
              end else begin
                state <= ST_IDLE;
              end
            end
          end
        end
        ST_PAD: begin
          if (load_ok) begin
            byte_cnt <= cnt_next;
            if (pad_last) state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  axis_out_reg u_out (
    .clk     (clk),
    .rst     (rst),
    .load    (out_load),
    .data    (out_data),
    .last    (out_last),
    .user    (out_user),
    .load_ok (load_ok),
    .m       (m_axis)
  );

endmodule

// File: doc/eth_hdr_axis_tx.md
# eth_hdr_axis_tx

Ethernet frame serializer that sits directly downstream of the ARP frame transmitter and any other Ethernet-payload producer. It accepts a parallel Ethernet header (dest MAC, src MAC, EtherType) plus an 8-bit AXI-stream payload and emits a single 8-bit AXI-stream frame: 14 header bytes, then the payload. When the frame is shorter than the minimum, it pads with zero bytes. Its output feeds the MAC TX FIFO; no FCS is generated here.

## Interface
- `ENABLE_PADDING`, default 1: pad frames shorter than `MIN_FRAME_LENGTH` with 0x00.
- `MIN_FRAME_LENGTH`, default 60: minimum output length in bytes, header included, FCS excluded. Legal range 15..1514.

- `clk`  in  1  sole clock; all logic is rising-edge.
- `rst`  in  1  synchronous, active-high reset.
- `s_eth_hdr_valid`  in  1  header valid.
- `s_eth_hdr_ready`  out  1  header accepted when valid && ready.
- `s_eth_dest_mac`  in  48  destination MAC; first on wire, MSB byte first.
- `s_eth_src_mac`  in  48  source MAC.
- `s_eth_type`  in  16  EtherType.
- `s_eth_payload_axis_tdata`  in  8  payload byte.
- `s_eth_payload_axis_tvalid`  in  1  payload valid.
- `s_eth_payload_axis_tready`  out  1  payload ready.
- `s_eth_payload_axis_tlast`  in  1  last payload byte.
- `s_eth_payload_axis_tuser`  in  1  error flag, sampled on the tlast beat.
- `m_axis_tdata`  out  8  frame byte.
- `m_axis_tvalid`  out  1  frame valid.
- `m_axis_tready`  in  1  sink ready.
- `m_axis_tlast`  out  1  last frame byte.
- `m_axis_tuser`  out  1  frame error; valid only on the tlast beat.
- `busy`  out  1  high whenever the state is not IDLE.

## Operation
- **State machine:** IDLE, HEADER, PAYLOAD, PAD.
- **IDLE:**
  - `s_eth_hdr_ready` = 1, driven combinationally from the state.
  - On a header handshake, capture all three fields, clear `byte_cnt` (16 bit) and `ptr` (4 bit), and go to HEADER.
- **Output register:** a single stage. It loads when `load_ok = !m_axis_tvalid || m_axis_tready`, a combinational path from `m_axis_tready`.
- **HEADER:**
  - Each cycle with `load_ok`, emit header byte `ptr`: bytes 0–5 are dest MAC [47:40]..[7:0], bytes 6–11 are src MAC, bytes 12–13 are the type MSB then LSB.
  - Increment `ptr` and `byte_cnt`. After byte 13 is loaded, go to PAYLOAD.
- **PAYLOAD:**
  - `s_eth_payload_axis_tready = load_ok`; the byte passes to output; `byte_cnt` increments and saturates at 0xFFFF.
  - On the input tlast beat, the next state depends on length (`byte_cnt` before increment):
    - If `ENABLE_PADDING` and `byte_cnt+1 < MIN_FRAME_LENGTH`: emit the byte with tlast=0, latch tuser into `pad_user`, go to PAD.
    - Otherwise: emit with tlast=1 and tuser from input, go to IDLE.
- **PAD:**
  - Emit 0x00 per `load_ok`, incrementing `byte_cnt`.
  - The byte where `byte_cnt+1 == MIN_FRAME_LENGTH` carries tlast=1 and tuser=`pad_user`; then go to IDLE.
- **Payload ready:** `s_eth_payload_axis_tready` = 0 outside PAYLOAD.
- **Header ready:** `s_eth_hdr_ready` = 0 outside IDLE.
- **Input assumptions:** payload beats are never dropped or inserted. There is no empty-payload case, since every payload packet has at least one beat.

## Timing
- **Reset values:** `s_eth_hdr_ready`=0 while `rst` is asserted and 1 in the first IDLE cycle after. `s_eth_payload_axis_tready`=0, `m_axis_tdata`=0, `m_axis_tvalid`=0, `m_axis_tlast`=0, `m_axis_tuser`=0, `busy`=0, state=IDLE, counters=0.
- **Header latency:** header handshake in cycle N; HEADER is entered at N+1 and byte 0 is loaded at the end of N+1; `m_axis_tvalid` is high at N+2.
- **Throughput:** one byte per cycle under continuous `m_axis_tready` = 1. No bubbles across HEADER→PAYLOAD or PAYLOAD→PAD.
- **Frame-to-frame gap:** the final beat is loaded in cycle M, IDLE holds at M+1 (`hdr_ready`=1), so a back-to-back header is accepted at M+1. That gives at most 1 idle output cycle between frames.
- **Backpressure:** with `m_axis_tready`=0 and `tvalid`=1, the output holds stable and no state, pointer or counter advances.
- **Stalled source:** `s_eth_payload_axis_tvalid`=0 in PAYLOAD loads nothing; `m_axis_tvalid` drops after the current beat drains.
- **Reset mid-frame:** the next edge forces all reset values. The partial frame is truncated without tlast, and the downstream FIFO drops it on its own reset.

## Structure
- **Shared package `eth_pkg`:**
  - `ETH_HDR_LEN` = 14 and `ETH_MIN_FRAME_LEN` = 60.
  - The state encoding for IDLE/HEADER/PAYLOAD/PAD.
- **Sub-modules:** the output register stage is a natural sub-module, `axis_out_reg`, with an 8-bit data, tlast and tuser pipeline register and `load_ok` logic. It is reusable by the ARP and IP TX paths. Everything else is kept in one module.

## Test plan
- **ARP reply, padded:** dest=FF:FF:FF:FF:FF:FF, src=02:00:00:00:00:01, type=0x0806, 28-byte payload 0x01..0x1C, sink always ready → 60 bytes: FF×6, 02 00 00 00 00 01, 08 06, 01..1C, then 18×00 with tlast on byte 59 only.
- **No padding needed:** 100-byte payload → exactly 114 bytes, tlast on the payload's last byte, no pad; `busy` falls the cycle after it is loaded.
- **Error on short frame:** 10-byte payload with tuser=1 on its tlast → 60 bytes, tuser=1 only on byte 59; repeat with `ENABLE_PADDING`=0 → 24 bytes, tuser=1 on byte 23.
- **Random backpressure:** random `m_axis_tready` (50%) and gappy payload `tvalid` over 200 frames of length 1..200 → byte-exact match to the reference model; output stable while stalled.
- **Back-to-back frames:** header 2 presented while frame 1 is in flight → accepted exactly one cycle after frame 1's final beat is loaded; ≤1 idle output cycle between frames.
- **Reset mid-frame:** `rst` pulsed while in PAD at byte 40 → all outputs at reset values the next cycle; a subsequent 28-byte frame is emitted correctly as 60 bytes.
